// File: rtl/mem_access_unit.sv
// Load/store access unit: accepts one aligned memory op from EX, drives the
// data-memory request until ack or timeout, then presents the raw load word.
module mem_access_unit #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic        ex_half,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        wb_wc,
    output logic        wb_half,
    output logic        err,
    output logic [1:0]  err_code
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          wb_valid_q, wb_valid_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          wb_wc_q, wb_wc_d;
    logic          wb_half_q, wb_half_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          op_load_q, op_load_d;
    logic          op_wc_q, op_wc_d;
    logic          op_half_q, op_half_d;

    logic one_op, aligned, accept;

    assign one_op  = ex_load ^ ex_store;
    assign aligned = ex_half ? ~ex_addr[0] : (ex_addr[1:0] == 2'b00);
    assign accept  = (state_q == IDLE) && ex_valid && one_op && aligned;
    assign stall   = accept || (state_q == BUSY);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_wc_d     = wb_wc_q;
        wb_half_d   = wb_half_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        op_load_d   = op_load_q;
        op_wc_d     = op_wc_q;
        op_half_d   = op_half_q;
        case (state_q)
            IDLE: begin
                if (ex_valid && !one_op) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b11;
                end else if (ex_valid && !aligned) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                end else if (accept) begin
                    state_d    = BUSY;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = ex_store;
                    mem_addr_d = {ex_addr[31:2], 2'b00};
                    op_load_d  = ex_load;
                    op_wc_d    = ex_addr[1];
                    op_half_d  = ex_half;
                    // Half stores replicate the halfword; byte enables pick the lane.
                    if (ex_store && ex_half) begin
                        mem_be_d    = ex_addr[1] ? 4'b1100 : 4'b0011;
                        mem_wdata_d = {ex_wdata[15:0], ex_wdata[15:0]};
                    end else begin
                        mem_be_d    = 4'b1111;
                        mem_wdata_d = ex_wdata;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d    = DONE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = op_load_q;
                    if (op_load_q) begin
                        wb_data_d = mem_rdata;
                        wb_wc_d   = op_wc_q;
                        wb_half_d = op_half_q;
                    end
                end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
                    state_d    = IDLE;
                    cnt_d      = cnt_q + CW'(1);
                    mem_req_d  = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_wc_q     <= 1'b0;
            wb_half_q   <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            op_load_q   <= 1'b0;
            op_wc_q     <= 1'b0;
            op_half_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_wc_q     <= wb_wc_d;
            wb_half_q   <= wb_half_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            op_load_q   <= op_load_d;
            op_wc_q     <= op_wc_d;
            op_half_q   <= op_half_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign wb_wc     = wb_wc_q;
    assign wb_half   = wb_half_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;
    logic        clk, rst;
    logic        ex_valid, ex_load, ex_store, ex_half;
    logic [31:0] ex_addr, ex_wdata;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid, wb_wc, wb_half, err;
    logic [31:0] wb_data;
    logic [1:0]  err_code;

    int vecs = 0;
    int miscompares = 0;

    mem_access_unit #(.MAX_WAIT(16)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store), .ex_half(ex_half),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_wc(wb_wc), .wb_half(wb_half),
        .err(err), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic ld, input logic st, input logic hf,
                         input logic [31:0] addr, input logic [31:0] wd);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_half = hf;
        ex_addr = addr; ex_wdata = wd;
        #1;
    endtask

    // Accept, hold BUSY for k cycles (ack on the k-th), then check DONE and return to IDLE.
    task automatic run_op(input string name, input logic ld, input logic st, input logic hf,
                          input logic [31:0] addr, input logic [31:0] wd, input int k,
                          input logic [31:0] rd, input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wd, input logic e_wb, input logic e_wc,
                          input logic e_hf);
        drive(ld, st, hf, addr, wd);
        check_val({name, " accept_stall"}, 32'(stall), 32'd1);
        for (int i = 1; i <= k; i++) begin
            tick();
            check_val({name, " busy_req"}, 32'(mem_req), 32'd1);
            check_val({name, " busy_stall"}, 32'(stall), 32'd1);
            check_val({name, " addr"}, mem_addr, e_addr);
            check_val({name, " be"}, 32'(mem_be), 32'(e_be));
            check_val({name, " we"}, 32'(mem_we), 32'(st));
            check_val({name, " busy_wbv"}, 32'(wb_valid), 32'd0);
            if (st) check_val({name, " wdata"}, mem_wdata, e_wd);
            if (i == k) begin
                mem_ack = 1'b1;
                mem_rdata = rd;
            end
        end
        tick();
        mem_ack = 1'b0;
        ex_valid = 1'b0;
        #1;
        $display("op %s addr=0x%08h k=%0d req=%0b wbv=%0b wb=0x%08h", name, addr, k, mem_req,
                 wb_valid, wb_data);
        check_val({name, " done_req"}, 32'(mem_req), 32'd0);
        check_val({name, " done_stall"}, 32'(stall), 32'd0);
        check_val({name, " done_wbv"}, 32'(wb_valid), 32'(e_wb));
        check_val({name, " done_err"}, 32'(err), 32'd0);
        if (e_wb) begin
            check_val({name, " wb_data"}, wb_data, rd);
            check_val({name, " wb_wc"}, 32'(wb_wc), 32'(e_wc));
            check_val({name, " wb_half"}, 32'(wb_half), 32'(e_hf));
        end
        tick();
        check_val({name, " idle_wbv"}, 32'(wb_valid), 32'd0);
    endtask

    task automatic err_case(input string name, input logic ld, input logic st, input logic hf,
                            input logic [31:0] addr, input logic [1:0] code);
        drive(ld, st, hf, addr, 32'h0);
        check_val({name, " stall"}, 32'(stall), 32'd0);
        tick();
        ex_valid = 1'b0;
        $display("err %s addr=0x%08h err=%0b code=%0b req=%0b", name, addr, err, err_code, mem_req);
        check_val({name, " req"}, 32'(mem_req), 32'd0);
        check_val({name, " err"}, 32'(err), 32'd1);
        check_val({name, " code"}, 32'(err_code), 32'(code));
        tick();
        check_val({name, " err_pulse"}, 32'(err), 32'd0);
        check_val({name, " req_after"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_half = 1'b0;
        ex_addr = '0; ex_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_val("rst req/we/be", {29'd0, mem_req, mem_we, |mem_be}, 32'd0);
        check_val("rst addr", mem_addr, 32'd0);
        check_val("rst wdata", mem_wdata, 32'd0);
        check_val("rst wb_data", wb_data, 32'd0);
        check_val("rst flags", {27'd0, wb_valid, wb_wc, wb_half, err, |err_code}, 32'd0);
        check_val("rst stall", 32'(stall), 32'd0);
        tick();

        run_op("ld_word", 1, 0, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0, 1, 0, 0);
        run_op("st_half_hi", 0, 1, 1, 32'h6, 32'h1234ABCD, 1, 32'h0, 32'h4, 4'b1100, 32'hABCDABCD, 0, 0, 0);
        check_val("wb_hold data", wb_data, 32'hDEADBEEF);
        check_val("wb_hold half", 32'(wb_half), 32'd0);
        run_op("ld_half_hi", 1, 0, 1, 32'h102, 32'h0, 2, 32'h80017FFF, 32'h100, 4'b1111, 32'h0, 1, 1, 1);
        run_op("st_word", 0, 1, 0, 32'h200, 32'hCAFEF00D, 1, 32'h0, 32'h200, 4'b1111, 32'hCAFEF00D, 0, 0, 0);
        run_op("st_half_lo", 0, 1, 1, 32'h8, 32'h00009876, 2, 32'h0, 32'h8, 4'b0011, 32'h98769876, 0, 0, 0);
        run_op("ld_half_lo", 1, 0, 1, 32'h104, 32'h0, 1, 32'h11112222, 32'h104, 4'b1111, 32'h0, 1, 0, 1);

        err_case("mis_word_ld", 1, 0, 0, 32'h101, 2'b01);
        err_case("mis_half_ld", 1, 0, 1, 32'h103, 2'b01);
        err_case("mis_word_st", 0, 1, 0, 32'h102, 2'b01);
        err_case("both_ops", 1, 1, 0, 32'h100, 2'b11);
        err_case("no_op", 0, 0, 0, 32'h100, 2'b11);

        // Timeout: no ack for MAX_WAIT busy cycles.
        drive(1, 0, 0, 32'h300, 32'h0);
        check_val("to accept_stall", 32'(stall), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            ex_valid = 1'b0;
            check_val("to busy_req", 32'(mem_req), 32'd1);
        end
        tick();
        #1;
        $display("timeout req=%0b err=%0b code=%0b stall=%0b", mem_req, err, err_code, stall);
        check_val("to req_low", 32'(mem_req), 32'd0);
        check_val("to err", 32'(err), 32'd1);
        check_val("to code", 32'(err_code), 32'd2);
        check_val("to wbv", 32'(wb_valid), 32'd0);
        check_val("to stall", 32'(stall), 32'd0);
        tick();
        check_val("to err_pulse", 32'(err), 32'd0);

        run_op("ack_at_limit", 1, 0, 0, 32'h310, 32'h0, 16, 32'h0BADF00D, 32'h310, 4'b1111, 32'h0, 1, 0, 0);

        // Reset two cycles into BUSY with an ack pending.
        drive(1, 0, 0, 32'h400, 32'h0);
        tick();
        ex_valid = 1'b0;
        tick();
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h55AA55AA;
        tick();
        rst = 1'b0;
        #1;
        $display("rst_busy req=%0b wbv=%0b err=%0b wb=0x%08h", mem_req, wb_valid, err, wb_data);
        check_val("rstb req", 32'(mem_req), 32'd0);
        check_val("rstb wbv", 32'(wb_valid), 32'd0);
        check_val("rstb err", 32'(err), 32'd0);
        check_val("rstb wb_data", wb_data, 32'd0);
        tick();
        mem_ack = 1'b0;
        check_val("rstb idle_ack_wbv", 32'(wb_valid), 32'd0);
        check_val("rstb idle_ack_req", 32'(mem_req), 32'd0);
        run_op("after_rst", 1, 0, 0, 32'h404, 32'h0, 2, 32'h13579BDF, 32'h404, 4'b1111, 32'h0, 1, 0, 0);

        // Reset wins over a same-cycle accept.
        rst = 1'b1;
        drive(1, 0, 0, 32'h500, 32'h0);
        tick();
        rst = 1'b0;
        ex_valid = 1'b0;
        #1;
        $display("rst_accept req=%0b err=%0b", mem_req, err);
        check_val("rsta req", 32'(mem_req), 32'd0);
        check_val("rsta err", 32'(err), 32'd0);
        tick();
        check_val("rsta req_after", 32'(mem_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16: number of BUSY cycles without mem_ack before a timeout abort.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port ex_valid, input, 1: EX stage presents a memory operation.
REQ-005 SHALL have ports ex_load, ex_store, ex_half, input, 1 each: load op, store op, half-word width (0 = word).
REQ-006 SHALL have ports ex_addr and ex_wdata, input, 32 each: byte address and store data.
REQ-007 SHALL have port stall, output, 1: pipeline hold request.
REQ-008 SHALL have ports mem_req and mem_we, output, 1 each; mem_addr, output, 32; mem_be, output, 4; mem_wdata, output, 32: data-memory request bus.
REQ-009 SHALL have ports mem_ack, input, 1, and mem_rdata, input, 32: memory completion and read word.
REQ-010 SHALL have ports wb_valid, output, 1; wb_data, output, 32; wb_wc, output, 1; wb_half, output, 1: raw load word plus half-select and width, feeding the downstream half-word select/sign-extend stage as its D, wc and half_word_t.
REQ-011 SHALL have ports err, output, 1, and err_code, output, 2: one-cycle error pulse and cause.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 Accept: in IDLE with ex_valid=1 and exactly one of ex_load/ex_store high and address aligned (word: ex_addr[1:0]=00; half: ex_addr[0]=0); then -> BUSY.
REQ-014 Misaligned accept attempt SHALL not access memory, SHALL stay IDLE and SHALL pulse err with err_code=01 the next cycle.
REQ-015 ex_valid with both or neither of ex_load/ex_store SHALL not access memory and SHALL pulse err, err_code=11, the next cycle.
REQ-016 On accept, mem_addr SHALL register {ex_addr[31:2],2'b00}; mem_we=ex_store; loads mem_be=1111.
REQ-017 Word store: mem_be=1111, mem_wdata=ex_wdata; half store: mem_be=1100 if ex_addr[1] else 0011, mem_wdata={ex_wdata[15:0],ex_wdata[15:0]}.
REQ-018 mem_req SHALL be high for every BUSY cycle, rising the cycle after accept; mem_addr/we/be/wdata SHALL be stable while mem_req=1.
REQ-019 BUSY with mem_ack=1: -> DONE; for loads wb_data SHALL capture mem_rdata, wb_wc capture ex_addr[1], wb_half capture ex_half.
REQ-020 DONE SHALL last exactly one cycle, mem_req=0, wb_valid=1 for loads only (0 for stores), then -> IDLE.
REQ-021 stall SHALL be combinational: high in the accept cycle and every BUSY cycle, low in IDLE (non-accept) and DONE.
REQ-022 Latency: accept at cycle T, mem_ack first seen at T+k (k>=1), wb_valid at T+k+1; minimum accept-to-wb_valid 2 cycles.
REQ-023 Wait counter SHALL clear on entering BUSY and increment per BUSY cycle with mem_ack=0; on reaching MAX_WAIT -> IDLE, mem_req low next cycle, err pulse err_code=10, no wb_valid.
REQ-024 mem_ack in the cycle the counter hits MAX_WAIT SHALL take priority (normal completion, no error).
REQ-025 mem_ack while IDLE or DONE SHALL be ignored.
REQ-026 No new operation SHALL be accepted in BUSY or DONE; ex_valid there is ignored (pipeline held by stall).
REQ-027 wb_data, wb_wc, wb_half SHALL hold their last value until the next load completion.

Reset
REQ-028 rst=1 SHALL force state IDLE, counter 0, mem_req=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0, wb_valid=0, wb_data=0, wb_wc=0, wb_half=0, err=0, err_code=00 at the next edge.
REQ-029 rst during BUSY/DONE SHALL abort without wb_valid or err; a pending mem_ack is discarded.
REQ-030 rst SHALL override acceptance in the same cycle.

Verification
REQ-031 Word load addr 0x100, ack after 3 cycles rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, wb_valid at T+4, wb_data 0xDEADBEEF, wb_half=0.
REQ-032 Half store addr 0x0000_0006, wdata 0x1234ABCD, ack 1 cycle -> mem_addr 0x4, be 1100, mem_wdata 0xABCDABCD, no wb_valid.
REQ-033 Half load addr 0x102, rdata 0x8001_7FFF -> wb_wc=1, wb_half=1, wb_data 0x80017FFF.
REQ-034 Word load addr 0x101 -> no mem_req, err=1 code 01 next cycle; load+store both high -> code 11.
REQ-035 Load, mem_ack never -> mem_req high 16 cycles, err code 10, stall low afterwards; ack on 16th cycle -> normal completion.
REQ-036 rst asserted 2 cycles into BUSY then ack -> mem_req 0, no wb_valid, next op accepted normally.
